// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory controller between the instruction-fetch (flash) and data (PSRAM) ports,
// round-robin on collision, one transaction in flight. Optional fetch buffer: define IFETCH_BUF_EN.
package spi_mem_pkg;
  typedef enum logic [1:0] {
    TYPE_IMEM_READ  = 2'd0,
    TYPE_DMEM_READ  = 2'd1,
    TYPE_DMEM_WRITE = 2'd2
  } mem_type_t;
endpackage

module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            imem_req_in,
  input  logic [15:0]     imem_addr_in,
  output logic            imem_ack_out,
  output logic [15:0]     imem_data_out,
  input  logic            dmem_req_in,
  input  logic            dmem_we_in,
  input  logic [15:0]     dmem_addr_in,
  input  logic [7:0]      dmem_wdata_in,
  output logic            dmem_ack_out,
  output logic [7:0]      dmem_rdata_out,
  output logic            err_out,
  output logic [15:0]     mem_addr_out,
  output logic            mem_addr_valid_out,
  output mem_type_t       mem_type_out,
  output logic [7:0]      mem_wdata_out,
  input  logic            mem_busy_in,
  input  logic [15:0]     mem_flash_data_in,
  input  logic            mem_flash_valid_in,
  input  logic [7:0]      mem_psram_data_in,
  input  logic            mem_psram_valid_in
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_TO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACK
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last_imem;
  logic            r_cur_imem;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_hit, w_grant, w_grant_imem, w_done, w_timeout;
  logic [15:0]     r_imem_data;
  logic [7:0]      r_dmem_rdata;
  logic            r_err;
  logic [15:0]     r_mem_addr;
  logic            r_mem_addr_valid;
  mem_type_t       r_mem_type;
  logic [7:0]      r_mem_wdata;

`ifdef IFETCH_BUF_EN
  logic            r_buf_vld;
  logic [14:0]     r_buf_tag;
  logic [15:0]     r_buf_data;
  assign w_hit = imem_req_in && r_buf_vld && (r_buf_tag == imem_addr_in[15:1]);
`else
  assign w_hit = 1'b0;
`endif

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_imem = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A buffer hit needs no SPI access, so it is served even while the controller is busy.
        if (w_hit) begin
          w_state_nxt = S_ACK;
        end else if ((imem_req_in || dmem_req_in) && !mem_busy_in) begin
          w_grant      = 1'b1;
          w_grant_imem = imem_req_in && (!dmem_req_in || !r_last_imem);
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_cnt_inc == C_TO) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ACK;
        end else if (mem_busy_in) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!mem_busy_in) begin
          w_done      = 1'b1;
          w_state_nxt = S_ACK;
        end else if (w_cnt_inc == C_TO) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_last_imem      <= 1'b0;
      r_cur_imem       <= 1'b0;
      r_cnt            <= '0;
      r_imem_data      <= 16'h0000;
      r_dmem_rdata     <= 8'h00;
      r_err            <= 1'b0;
      r_mem_addr       <= 16'h0000;
      r_mem_addr_valid <= 1'b0;
      r_mem_type       <= TYPE_IMEM_READ;
      r_mem_wdata      <= 8'h00;
`ifdef IFETCH_BUF_EN
      r_buf_vld        <= 1'b0;
      r_buf_tag        <= 15'h0000;
      r_buf_data       <= 16'h0000;
`endif
    end else begin
      r_mem_addr_valid <= w_grant;
      if (w_grant) begin
        r_last_imem <= w_grant_imem;
        r_cur_imem  <= w_grant_imem;
        if (w_grant_imem) begin
          r_mem_addr  <= {imem_addr_in[15:1], 1'b0};
          r_mem_type  <= TYPE_IMEM_READ;
          r_mem_wdata <= 8'h00;
        end else begin
          r_mem_addr  <= dmem_addr_in;
          r_mem_type  <= dmem_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
          r_mem_wdata <= dmem_wdata_in;
        end
      end
`ifdef IFETCH_BUF_EN
      if (r_state == S_IDLE && w_hit) begin
        r_cur_imem  <= 1'b1;
        r_imem_data <= r_buf_data;
      end
`endif
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_done) begin
        if (r_cur_imem) begin
          if (mem_flash_valid_in) begin
            r_imem_data <= mem_flash_data_in;
`ifdef IFETCH_BUF_EN
            r_buf_vld   <= 1'b1;
            r_buf_tag   <= r_mem_addr[15:1];
            r_buf_data  <= mem_flash_data_in;
`endif
          end
        end else if (r_mem_type == TYPE_DMEM_READ && mem_psram_valid_in) begin
          r_dmem_rdata <= mem_psram_data_in;
        end
      end
      // Aborted transfers return zero data; a write abort leaves the read byte untouched.
      if (w_timeout) begin
        r_err <= 1'b1;
        if (r_cur_imem)                        r_imem_data  <= 16'h0000;
        else if (r_mem_type == TYPE_DMEM_READ) r_dmem_rdata <= 8'h00;
      end
    end
  end

  assign imem_ack_out       = (r_state == S_ACK) && r_cur_imem;
  assign dmem_ack_out       = (r_state == S_ACK) && !r_cur_imem;
  assign imem_data_out      = r_imem_data;
  assign dmem_rdata_out     = r_dmem_rdata;
  assign err_out            = r_err;
  assign mem_addr_out       = r_mem_addr;
  assign mem_addr_valid_out = r_mem_addr_valid;
  assign mem_type_out       = r_mem_type;
  assign mem_wdata_out      = r_mem_wdata;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: table of single-port transactions against a behavioural
// SPI controller model, plus hand sequences for arbitration, timeout and mid-transaction reset.
module tb_spi_mem_arbiter;
  import spi_mem_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        imem_req_in = 1'b0;
  logic [15:0] imem_addr_in = 16'h0000;
  logic        imem_ack_out;
  logic [15:0] imem_data_out;
  logic        dmem_req_in = 1'b0;
  logic        dmem_we_in = 1'b0;
  logic [15:0] dmem_addr_in = 16'h0000;
  logic [7:0]  dmem_wdata_in = 8'h00;
  logic        dmem_ack_out;
  logic [7:0]  dmem_rdata_out;
  logic        err_out;
  logic [15:0] mem_addr_out;
  logic        mem_addr_valid_out;
  mem_type_t   mem_type_out;
  logic [7:0]  mem_wdata_out;
  logic        mem_busy_in = 1'b0;
  logic [15:0] mem_flash_data_in = 16'h0000;
  logic        mem_flash_valid_in = 1'b0;
  logic [7:0]  mem_psram_data_in = 8'h00;
  logic        mem_psram_valid_in = 1'b0;

  spi_mem_arbiter dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .imem_req_in(imem_req_in), .imem_addr_in(imem_addr_in),
    .imem_ack_out(imem_ack_out), .imem_data_out(imem_data_out),
    .dmem_req_in(dmem_req_in), .dmem_we_in(dmem_we_in), .dmem_addr_in(dmem_addr_in),
    .dmem_wdata_in(dmem_wdata_in), .dmem_ack_out(dmem_ack_out), .dmem_rdata_out(dmem_rdata_out),
    .err_out(err_out), .mem_addr_out(mem_addr_out), .mem_addr_valid_out(mem_addr_valid_out),
    .mem_type_out(mem_type_out), .mem_wdata_out(mem_wdata_out), .mem_busy_in(mem_busy_in),
    .mem_flash_data_in(mem_flash_data_in), .mem_flash_valid_in(mem_flash_valid_in),
    .mem_psram_data_in(mem_psram_data_in), .mem_psram_valid_in(mem_psram_valid_in)
  );

  always #5 clk_in = ~clk_in;

  // Controller model: busy the cycle after the address strobe, 3 busy cycles, then result + valid.
  logic [7:0]  psram [0:65535];
  logic [15:0] fl_word = 16'h0000;
  logic        model_dead = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_addr = 16'h0000;
  mem_type_t   m_type = TYPE_IMEM_READ;
  logic [7:0]  m_wdata = 8'h00;

  always @(negedge clk_in) begin
    if (reset_in) begin
      mem_busy_in = 1'b0; mem_flash_valid_in = 1'b0; mem_psram_valid_in = 1'b0; m_cnt = 0;
    end else begin
      mem_flash_valid_in = 1'b0;
      mem_psram_valid_in = 1'b0;
      if (mem_addr_valid_out && !model_dead) begin
        mem_busy_in = 1'b1; m_cnt = 3;
        m_addr = mem_addr_out; m_type = mem_type_out; m_wdata = mem_wdata_out;
      end else if (mem_busy_in) begin
        if (m_cnt == 0) begin
          mem_busy_in = 1'b0;
          case (m_type)
            TYPE_IMEM_READ: begin mem_flash_data_in = fl_word; mem_flash_valid_in = 1'b1; end
            TYPE_DMEM_READ: begin mem_psram_data_in = psram[m_addr]; mem_psram_valid_in = 1'b1; end
            default:        psram[m_addr] = m_wdata;
          endcase
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  int n_valid = 0, n_both = 0, n_ack = 0;
  always @(negedge clk_in) begin
    if (mem_addr_valid_out)           n_valid = n_valid + 1;
    if (imem_ack_out && dmem_ack_out) n_both  = n_both + 1;
    if (imem_ack_out || dmem_ack_out) n_ack   = n_ack + 1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic        is_imem;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] fl;
    int          exp_lat;
    int          exp_vld;
    logic [15:0] exp_addr;
    mem_type_t   exp_type;
    logic [15:0] exp_data;
  } vec_t;

`ifdef IFETCH_BUF_EN
  localparam int          HL = 1, HV = 0;
  localparam logic [15:0] D7 = 16'h7E57, D8 = 16'h7E57;
`else
  localparam int          HL = 6, HV = 1;
  localparam logic [15:0] D7 = 16'h0BAD, D8 = 16'h0CAB;
`endif

  task automatic run_vec(input vec_t v, input string tag);
    int lat; int vc0; logic gi; logic gd;
    vc0 = n_valid; lat = 0; gi = 1'b0; gd = 1'b0;
    fl_word = v.fl;
    if (v.is_imem) begin
      imem_req_in = 1'b1; imem_addr_in = v.addr;
    end else begin
      dmem_req_in = 1'b1; dmem_we_in = v.we; dmem_addr_in = v.addr; dmem_wdata_in = v.wdata;
    end
    while (lat < 60 && !gi && !gd) begin
      @(negedge clk_in);
      lat = lat + 1;
      gi = imem_ack_out; gd = dmem_ack_out;
    end
    imem_req_in = 1'b0; dmem_req_in = 1'b0;
    chk({tag, "_ack_port"}, {30'd0, gi, gd}, v.is_imem ? 32'd2 : 32'd1);
    chk({tag, "_latency"}, lat, v.exp_lat);
    if (v.is_imem)   chk({tag, "_imem_data"}, imem_data_out, v.exp_data);
    else if (!v.we)  chk({tag, "_dmem_rdata"}, dmem_rdata_out, v.exp_data);
    else             chk({tag, "_wdata"}, m_wdata, v.wdata);
    chk({tag, "_valid_cycles"}, n_valid - vc0, v.exp_vld);
    if (v.exp_vld != 0) begin
      chk({tag, "_mem_addr"}, m_addr, v.exp_addr);
      chk({tag, "_mem_type"}, m_type, v.exp_type);
    end
    @(negedge clk_in);
    chk({tag, "_ack_pulse"}, {imem_ack_out, dmem_ack_out}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_in); reset_in = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  vec_t vecs[10];
  vec_t v;

  initial begin
    int nacks; int guard; int lat; int a0; int b0; logic [3:0] seq;
    vecs[0] = '{1'b1, 1'b0, 16'h0123, 8'h00, 16'hBEEF, 6, 1, 16'h0122, TYPE_IMEM_READ, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h4000, 8'h5A, 16'h0000, 6, 1, 16'h4000, TYPE_DMEM_WRITE, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h4000, 8'h00, 16'h0000, 6, 1, 16'h4000, TYPE_DMEM_READ, 16'h005A};
    vecs[3] = '{1'b1, 1'b0, 16'h8001, 8'h00, 16'h1234, 6, 1, 16'h8000, TYPE_IMEM_READ, 16'h1234};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 8'hC3, 16'h0000, 6, 1, 16'hFFFF, TYPE_DMEM_WRITE, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 16'h0000, 6, 1, 16'hFFFF, TYPE_DMEM_READ, 16'h00C3};
    vecs[6] = '{1'b1, 1'b0, 16'h0010, 8'h00, 16'h7E57, 6, 1, 16'h0010, TYPE_IMEM_READ, 16'h7E57};
    vecs[7] = '{1'b1, 1'b0, 16'h0010, 8'h00, 16'h0BAD, HL, HV, 16'h0010, TYPE_IMEM_READ, D7};
    vecs[8] = '{1'b1, 1'b0, 16'h0011, 8'h00, 16'h0CAB, HL, HV, 16'h0010, TYPE_IMEM_READ, D8};
    vecs[9] = '{1'b0, 1'b0, 16'h4000, 8'h00, 16'h0000, 6, 1, 16'h4000, TYPE_DMEM_READ, 16'h005A};

    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    chk("reset_outputs",
        {imem_ack_out, imem_data_out, dmem_ack_out, dmem_rdata_out, err_out,
         mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out}, '0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Both ports held from reset: grants must alternate starting with IMEM.
    do_reset();
    b0 = n_both; nacks = 0; guard = 0; seq = 4'b0000;
    imem_addr_in = 16'h3000; dmem_addr_in = 16'h4000; dmem_we_in = 1'b0; fl_word = 16'h1111;
    imem_req_in = 1'b1; dmem_req_in = 1'b1;
    while (nacks < 4 && guard < 200) begin
      @(negedge clk_in);
      guard = guard + 1;
      if (imem_ack_out) begin seq = {seq[2:0], 1'b1}; nacks = nacks + 1; imem_addr_in = imem_addr_in + 16'd2; end
      if (dmem_ack_out) begin seq = {seq[2:0], 1'b0}; nacks = nacks + 1; end
    end
    imem_req_in = 1'b0; dmem_req_in = 1'b0;
    chk("arb_ack_count", nacks, 4);
    chk("arb_order", seq, 4'b1010);
    chk("arb_no_dual_ack", n_both - b0, 0);
    @(negedge clk_in);

    // Controller never goes busy: forced abort with zero data and sticky error.
    model_dead = 1'b1; lat = 0;
    imem_req_in = 1'b1; imem_addr_in = 16'h2000;
    while (lat < 1100 && !imem_ack_out) begin
      @(negedge clk_in);
      lat = lat + 1;
    end
    imem_req_in = 1'b0;
    chk("to_ack_seen", imem_ack_out, 1'b1);
    chk("to_latency_window", (lat >= 1023 && lat <= 1027), 1'b1);
    chk("to_data_zero", imem_data_out, 16'h0000);
    chk("to_err_set", err_out, 1'b1);
    @(negedge clk_in);
    model_dead = 1'b0;
    v = '{1'b1, 1'b0, 16'h2000, 8'h00, 16'h5555, 6, 1, 16'h2000, TYPE_IMEM_READ, 16'h5555};
    run_vec(v, "after_to");
    chk("to_err_sticky", err_out, 1'b1);

    // Reset while the DMEM read sits in WAIT_DONE: no ack, everything back to zero.
    dmem_req_in = 1'b1; dmem_we_in = 1'b0; dmem_addr_in = 16'h4000;
    repeat (4) @(negedge clk_in);
    a0 = n_ack;
    reset_in = 1'b1; dmem_req_in = 1'b0;
    @(negedge clk_in);
    chk("rst_mid_outputs",
        {imem_ack_out, imem_data_out, dmem_ack_out, dmem_rdata_out, err_out,
         mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out}, '0);
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("rst_mid_no_ack", n_ack - a0, 0);
    v = '{1'b0, 1'b0, 16'h4000, 8'h00, 16'h0000, 6, 1, 16'h4000, TYPE_DMEM_READ, 16'h005A};
    run_vec(v, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
